// File: rtl/rast_pkg.sv
// Shared types and defaults for the line rasterizer: coordinate/colour types,
// Bresenham delta/error widths and the FSM state encoding.
package rast_pkg;

   typedef logic [10:0]        coord_t;
   typedef logic [2:0]         color_t;
   typedef logic signed [11:0] delta_t;
   typedef logic signed [12:0] err_t;

   typedef enum logic [1:0] {IDLE, SETUP, DRAW} rast_state_t;

   localparam int DEF_H_RES = 640;
   localparam int DEF_V_RES = 480;

endpackage

// File: rtl/rast_step.sv
// One Bresenham step: next (x, y, err) from the current position and the line's
// constant deltas. Both axis decisions use the pre-step error.
module rast_step
   import rast_pkg::*;
(
   input  coord_t x,
   input  coord_t y,
   input  err_t   err,
   input  delta_t dx,
   input  delta_t dy,
   input  logic   sx_neg,
   input  logic   sy_neg,
   output coord_t nx,
   output coord_t ny,
   output err_t   nerr
);

   logic signed [13:0] e2;
   logic               step_x;
   logic               step_y;

   always_comb begin
      e2     = {err, 1'b0};
      step_x = (e2 >= 14'(dy));
      step_y = (e2 <= 14'(dx));

      nerr = err;
      if (step_x) nerr = nerr + err_t'(dy);
      if (step_y) nerr = nerr + err_t'(dx);

      nx = x;
      if (step_x) nx = sx_neg ? (x - 11'd1) : (x + 11'd1);
      ny = y;
      if (step_y) ny = sy_neg ? (y - 11'd1) : (y + 11'd1);
   end

endmodule

// File: rtl/line_rasterizer.sv
// Pops line segments from the line queue and walks each one with Bresenham,
// offering visible pixels to the framebuffer and silently dropping clipped ones.
module line_rasterizer
   import rast_pkg::*;
#(
   parameter int H_RES = DEF_H_RES,
   parameter int V_RES = DEF_V_RES
)(
   input  logic        clk,
   input  logic        rst,
   input  coord_t      q_start_x,
   input  coord_t      q_start_y,
   input  coord_t      q_end_x,
   input  coord_t      q_end_y,
   input  color_t      q_color,
   input  logic        q_empty,
   output logic        q_read,
   output coord_t      pix_x,
   output coord_t      pix_y,
   output color_t      pix_color,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        busy,
   output rast_state_t dbg_state
);

   rast_state_t state, state_nxt;

   coord_t x, y, x1, y1;
   color_t color;
   delta_t dx, dy;
   err_t   err;
   logic   sx_neg, sy_neg;

   coord_t step_x, step_y;
   err_t   step_err;
   delta_t dx_c, dy_c;
   logic   visible, last, retire;

   rast_step u_step (
      .x      (x),
      .y      (y),
      .err    (err),
      .dx     (dx),
      .dy     (dy),
      .sx_neg (sx_neg),
      .sy_neg (sy_neg),
      .nx     (step_x),
      .ny     (step_y),
      .nerr   (step_err)
   );

   // Pixel port: a pixel moves when pix_valid & pix_ready at a clk edge; once
   // raised, pix_valid and the pixel fields hold until that transfer happens.
   assign visible   = (int'(x) < H_RES) && (int'(y) < V_RES);
   assign last      = (x == x1) && (y == y1);
   assign retire    = (state == DRAW) && (!visible || pix_ready);
   assign pix_valid = (state == DRAW) && visible;
   assign pix_x     = x;
   assign pix_y     = y;
   assign pix_color = color;
   assign busy      = (state != IDLE);
   assign dbg_state = state;

   // In SETUP, x/y still hold the start point latched at the pop.
   assign dx_c = (x1 >= x) ? delta_t'({1'b0, x1} - {1'b0, x})
                           : delta_t'({1'b0, x} - {1'b0, x1});
   assign dy_c = (y1 >= y) ? delta_t'({1'b0, y} - {1'b0, y1})
                           : delta_t'({1'b0, y1} - {1'b0, y});

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      q_read    = 1'b0;
      case (state)
         IDLE: begin
            q_read = !q_empty;
            if (!q_empty) state_nxt = SETUP;
         end
         SETUP:   state_nxt = DRAW;
         DRAW:    if (retire && last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x      <= '0;
         y      <= '0;
         x1     <= '0;
         y1     <= '0;
         color  <= '0;
         dx     <= '0;
         dy     <= '0;
         err    <= '0;
         sx_neg <= 1'b0;
         sy_neg <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!q_empty) begin
                  x     <= q_start_x;
                  y     <= q_start_y;
                  x1    <= q_end_x;
                  y1    <= q_end_y;
                  color <= q_color;
               end
            end
            SETUP: begin
               dx     <= dx_c;
               dy     <= dy_c;
               err    <= err_t'(dx_c) + err_t'(dy_c);
               sx_neg <= (x1 < x);
               sy_neg <= (y1 < y);
            end
            DRAW: begin
               if (retire && !last) begin
                  x   <= step_x;
                  y   <= step_y;
                  err <= step_err;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/line_rasterizer.md
# line_rasterizer

Consumes line segments from the line-register queue that sits after the AVG core and rasterizes each one into single-pixel framebuffer writes with an integer Bresenham walk. It pops one queue entry at a time and emits up to one pixel per clock over a valid/ready pixel port. Pixels outside the visible raster are clipped. It is the stage between the line queue and the framebuffer write port.

## Interface
Parameters:
- H_RES, 640: visible width; pixels with x >= H_RES are clipped.
- V_RES, 480: visible height; pixels with y >= V_RES are clipped.

Ports:
- clk  in  1  pixel-domain clock (same clock as the queue read side).
- rst  in  1  reset, synchronous, active-high.
- q_start_x, q_end_x  in  11  head-entry X endpoints, unsigned.
- q_start_y, q_end_y  in  11  head-entry Y endpoints, unsigned.
- q_color  in  3  head-entry colour.
- q_empty  in  1  queue empty; head fields are valid whenever q_empty=0.
- q_read  out  1  pop strobe; the queue advances at the clk edge where q_read=1.
- pix_x  out  11  pixel X.
- pix_y  out  11  pixel Y.
- pix_color  out  3  pixel colour.
- pix_valid  out  1  pixel offered.
- pix_ready  in  1  framebuffer accepts; a transfer happens when pix_valid & pix_ready.
- busy  out  1  high in any state other than IDLE.

## Operation
- States are IDLE, SETUP and DRAW.
- **IDLE**
  - q_read = !q_empty, combinational; it is never asserted in any other state.
  - On a pop, latch x0, y0, x1, y1 and colour, then go to SETUP.
- **SETUP** (one cycle) computes:
  - dx = |x1-x0| (12b signed, always >= 0).
  - dy = -|y1-y0| (12b signed).
  - sx = (x1>=x0) ? +1 : -1.
  - sy = (y1>=y0) ? +1 : -1.
  - err = dx+dy (13b signed).
  - Current position (x, y) is set to (x0, y0). Then go to DRAW.
- **DRAW**: the current pixel is offered when it is visible (x<H_RES and y<V_RES).
  - The pixel retires when it is transferred, or immediately when it is clipped (clipped pixels never wait on pix_ready).
  - If the retiring pixel is at (x1, y1), go to IDLE.
  - Otherwise step, with e2 = 2*err (14b signed):
    - if e2 >= dy: err += dy and x += sx;
    - if e2 <= dx: err += dx and y += sy;
    - both updates use the pre-step err.
- Pixels per line = max(dx, -dy)+1. A zero-length line emits exactly one pixel.
- Coordinates never wrap: the walk stays inside the bounding box of the endpoints.
- pix_color equals the latched colour for the whole line.

## Timing
- Reset values: state=IDLE, q_read=0, pix_valid=0, pix_x=0, pix_y=0, pix_color=0, busy=0. Internal registers are cleared.
- Reset mid-line abandons the line. The already-popped entry is lost; no further pop occurs until IDLE is reached with q_empty=0.
- Latency:
  - Cycle 0: q_empty falls while in IDLE, and q_read=1 in the same cycle.
  - Cycle 1: SETUP.
  - Cycle 2: first pixel offered (pix_valid=1).
- Throughput is one pixel per cycle with pix_ready held high.
- The last-pixel cycle is followed by one IDLE cycle, so back-to-back lines have a 2-cycle gap (IDLE, SETUP) between pixel streams.
- Backpressure: while pix_valid=1 and pix_ready=0, pix_x, pix_y and pix_color are held stable and internal state is frozen.
- pix_valid never drops without a transfer, except on reset.
- busy=1 in SETUP and DRAW.

## Structure
- Shared package rast_pkg holds:
  - coord_t (logic [10:0]);
  - color_t (logic [2:0]);
  - the state enum rast_state_t {IDLE, SETUP, DRAW};
  - the default resolution constants.
- One combinational sub-module, rast_step, computes next (x, y, err) from (x, y, err, dx, dy, sx, sy) so the step equation can be unit-tested alone.
- The top level holds the FSM, the endpoint/colour registers, the clip compare and the handshake.

## Test plan
- Horizontal line (0,0)->(3,0), colour 5, pix_ready=1:
  - one q_read pulse;
  - pixels (0,0),(1,0),(2,0),(3,0) on 4 consecutive cycles, each with colour 5;
  - first pixel 2 cycles after q_empty falls.
- Reverse diagonal (5,5)->(2,2): pixels (5,5),(4,4),(3,3),(2,2), then busy=0.
- Steep line (0,0)->(1,3): pixels (0,0),(0,1),(1,2),(1,3), in that order.
- Backpressure on (0,0)->(3,0): drop pix_ready for 3 cycles while (1,0) is offered:
  - (1,0) is held stable for all 3 cycles;
  - no pixel is skipped or duplicated;
  - 4 transfers total.
- Clipping with H_RES=640, line (638,0)->(642,0):
  - only (638,0) and (639,0) are transferred;
  - DRAW lasts 5 cycles;
  - then IDLE.
- Mixed sequence:
  - queue holds the single point (7,9)->(7,9) followed by (0,0)->(2,0): exactly one pixel (7,9), then the second line with a 2-cycle gap.
  - assert rst for 1 cycle mid-line: all outputs return to their reset values the next cycle, and the remaining pixels are never emitted.
